// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS instruction-fetch stage.
// Holds the PC, runs the instruction-memory handshake and owns the IF/ID register.
// Redirects fetch on exception, interrupt, jump or taken branch, and flushes
// wrong-path instructions.
// Ports: clk, reset (async, active-high)
//   IM_Req/IM_Addr/IM_Ready/IM_Data - instruction memory handshake
//   ID_Stall, ID_Taken, ID_IsBranch, ID_BranchTarget,
//   ID_Jump, ID_JumpTarget          - ID-stage control inputs
//   IRQ, Exception                  - trap requests
//   IF_PC, ID_PCPlus4, ID_Instruction, ID_Valid - stage outputs
// Optional feature macro: BRANCH_DELAY_SLOT_EN. When defined, the instruction
// completing fetch during a jump/branch redirect is kept as the delay slot.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] IRQ_PC   = 32'h8000_0004,
   parameter logic [31:0] EXC_PC   = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   output logic        IM_Req,
   output logic [31:0] IM_Addr,
   input  logic        IM_Ready,
   input  logic [31:0] IM_Data,
   input  logic        ID_Stall,
   input  logic        ID_Taken,
   input  logic        ID_IsBranch,
   input  logic [31:0] ID_BranchTarget,
   input  logic        ID_Jump,
   input  logic [31:0] ID_JumpTarget,
   input  logic        IRQ,
   input  logic        Exception,
   output logic [31:0] IF_PC,
   output logic [31:0] ID_PCPlus4,
   output logic [31:0] ID_Instruction,
   output logic        ID_Valid
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_q, drain_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic        skid_slot_q, skid_slot_d;
   logic        keep_q, keep_d;
   logic [31:0] idi_q, idi_d;
   logic [31:0] idp_q, idp_d;
   logic        idv_q, idv_d;

   logic        take_exc, take_irq, take_jmp, take_br;
   logic        trap, ctl, redirect;
   logic [31:0] target;
   logic [31:0] seq_pc;

   // Sequential increment keeps the supervisor bit (bit 31) fixed.
   function automatic logic [31:0] inc(input logic [31:0] a);
      return {a[31], a[30:0] + 31'd4};
   endfunction

   assign seq_pc = inc(pc_q);

   assign take_exc = Exception;
   assign take_irq = IRQ & ~pc_q[31];
   assign take_jmp = ID_Jump & idv_q & ~ID_Stall;
   assign take_br  = ID_IsBranch & ID_Taken & idv_q & ~ID_Stall;
   assign trap     = take_exc | take_irq;
   assign ctl      = take_jmp | take_br;
   assign redirect = trap | ctl;

   always_comb begin
      target = ID_BranchTarget;
      if (take_exc)      target = EXC_PC;
      else if (take_irq) target = IRQ_PC;
      else if (take_jmp) target = ID_JumpTarget;
   end

   // While draining, the bus keeps the abandoned address; PC already
   // points at the redirect target.
   assign IM_Req         = ~reset & (state_q != S_HOLD);
   assign IM_Addr        = (state_q == S_DRAIN) ? drain_q : pc_q;
   assign IF_PC          = pc_q;
   assign ID_PCPlus4     = idp_q;
   assign ID_Instruction = idi_q;
   assign ID_Valid       = idv_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_d      = drain_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      skid_slot_d  = skid_slot_q;
      keep_d       = keep_q;
      idi_d        = idi_q;
      idp_d        = idp_q;
      idv_d        = idv_q;

      unique case (state_q)
         S_FETCH: begin
            if (redirect) begin
               pc_d        = target;
               idv_d       = 1'b0;
               idi_d       = 32'h0;
               skid_slot_d = 1'b0;
               if (IM_Ready) begin
                  state_d = S_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
                  if (!trap) begin
                     idi_d = IM_Data;
                     idp_d = seq_pc;
                     idv_d = 1'b1;
                  end
`endif
               end else begin
                  state_d = S_DRAIN;
                  drain_d = pc_q;
                  keep_d  = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                  keep_d  = ~trap;
`endif
               end
            end else if (IM_Ready) begin
               if (!ID_Stall) begin
                  idi_d = IM_Data;
                  idp_d = seq_pc;
                  idv_d = 1'b1;
                  pc_d  = seq_pc;
               end else begin
                  skid_instr_d = IM_Data;
                  skid_pc4_d   = seq_pc;
                  skid_slot_d  = 1'b0;
                  state_d      = S_HOLD;
               end
            end else if (!ID_Stall) begin
               idv_d = 1'b0;
               idi_d = 32'h0;
            end
         end

         S_HOLD: begin
            if (redirect) begin
               pc_d        = target;
               idv_d       = 1'b0;
               idi_d       = 32'h0;
               skid_slot_d = 1'b0;
               state_d     = S_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
               if (!trap) begin
                  idi_d = skid_instr_q;
                  idp_d = skid_pc4_q;
                  idv_d = 1'b1;
               end
`endif
            end else if (!ID_Stall) begin
               idi_d       = skid_instr_q;
               idp_d       = skid_pc4_q;
               idv_d       = 1'b1;
               // A held delay slot was fetched after PC moved to the target.
               if (!skid_slot_q) pc_d = seq_pc;
               skid_slot_d = 1'b0;
               state_d     = S_FETCH;
            end
         end

         S_DRAIN: begin
            if (redirect) begin
               pc_d   = target;
               idv_d  = 1'b0;
               idi_d  = 32'h0;
               keep_d = 1'b0;
               if (IM_Ready) state_d = S_FETCH;
            end else if (IM_Ready) begin
               state_d = S_FETCH;
               keep_d  = 1'b0;
               if (!ID_Stall) begin
                  idv_d = 1'b0;
                  idi_d = 32'h0;
               end
`ifdef BRANCH_DELAY_SLOT_EN
               if (keep_q) begin
                  if (!ID_Stall) begin
                     idi_d = IM_Data;
                     idp_d = inc(drain_q);
                     idv_d = 1'b1;
                  end else begin
                     skid_instr_d = IM_Data;
                     skid_pc4_d   = inc(drain_q);
                     skid_slot_d  = 1'b1;
                     state_d      = S_HOLD;
                  end
               end
`endif
            end else if (!ID_Stall) begin
               idv_d = 1'b0;
               idi_d = 32'h0;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         drain_q      <= RESET_PC;
         skid_instr_q <= 32'h0;
         skid_pc4_q   <= 32'h0;
         skid_slot_q  <= 1'b0;
         keep_q       <= 1'b0;
         idi_q        <= 32'h0;
         idp_q        <= 32'h0;
         idv_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_q      <= drain_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         skid_slot_q  <= skid_slot_d;
         keep_q       <= keep_d;
         idi_q        <= idi_d;
         idp_q        <= idp_d;
         idv_q        <= idv_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit.
// Memory returns {16'h2008, addr[15:0] | 1}; expectations are hand-computed.
module tb_if_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic DS = 1'b1;
`else
   localparam logic DS = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        IM_Req;
   logic [31:0] IM_Addr;
   logic        IM_Ready;
   logic [31:0] IM_Data;
   logic        ID_Stall;
   logic        ID_Taken;
   logic        ID_IsBranch;
   logic [31:0] ID_BranchTarget;
   logic        ID_Jump;
   logic [31:0] ID_JumpTarget;
   logic        IRQ;
   logic        Exception;
   logic [31:0] IF_PC;
   logic [31:0] ID_PCPlus4;
   logic [31:0] ID_Instruction;
   logic        ID_Valid;

   int n_chk;
   int n_fail;

   if_fetch_unit dut (
      .clk(clk),
      .reset(reset),
      .IM_Req(IM_Req),
      .IM_Addr(IM_Addr),
      .IM_Ready(IM_Ready),
      .IM_Data(IM_Data),
      .ID_Stall(ID_Stall),
      .ID_Taken(ID_Taken),
      .ID_IsBranch(ID_IsBranch),
      .ID_BranchTarget(ID_BranchTarget),
      .ID_Jump(ID_Jump),
      .ID_JumpTarget(ID_JumpTarget),
      .IRQ(IRQ),
      .Exception(Exception),
      .IF_PC(IF_PC),
      .ID_PCPlus4(ID_PCPlus4),
      .ID_Instruction(ID_Instruction),
      .ID_Valid(ID_Valid)
   );

   assign IM_Data = {16'h2008, IM_Addr[15:0] | 16'h0001};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk           = 0;
      n_fail          = 0;
      reset           = 1'b1;
      IM_Ready        = 1'b1;
      ID_Stall        = 1'b0;
      ID_Taken        = 1'b0;
      ID_IsBranch     = 1'b0;
      ID_BranchTarget = 32'h0;
      ID_Jump         = 1'b0;
      ID_JumpTarget   = 32'h0;
      IRQ             = 1'b0;
      Exception       = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_req", 32'(IM_Req), 32'h0);
      chk("rst_pc", IF_PC, 32'h8000_0000);
      chk("rst_valid", 32'(ID_Valid), 32'h0);
      chk("rst_instr", ID_Instruction, 32'h0);
      chk("rst_pc4", ID_PCPlus4, 32'h0);
      reset = 1'b0;
      #1;
      chk("first_req", 32'(IM_Req), 32'h1);
      chk("first_addr", IM_Addr, 32'h8000_0000);

      // zero-wait stream
      tick();
      chk("seq1_addr", IM_Addr, 32'h8000_0004);
      chk("seq1_valid", 32'(ID_Valid), 32'h1);
      chk("seq1_pc4", ID_PCPlus4, 32'h8000_0004);
      chk("seq1_instr", ID_Instruction, 32'h2008_0001);
      tick();
      chk("seq2_addr", IM_Addr, 32'h8000_0008);
      chk("seq2_pc4", ID_PCPlus4, 32'h8000_0008);

      // taken branch, zero-wait
      ID_IsBranch     = 1'b1;
      ID_Taken        = 1'b1;
      ID_BranchTarget = 32'h8000_0040;
      tick();
      ID_IsBranch = 1'b0;
      ID_Taken    = 1'b0;
      chk("br_addr", IM_Addr, 32'h8000_0040);
      chk("br_valid", 32'(ID_Valid), 32'(DS));
      chk("br_instr", ID_Instruction, DS ? 32'h2008_0009 : 32'h0);
      tick();
      chk("br_tgt_instr", ID_Instruction, 32'h2008_0041);
      chk("br_tgt_valid", 32'(ID_Valid), 32'h1);
      chk("br_next_addr", IM_Addr, 32'h8000_0044);

      // stall while fetch completes
      ID_Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_req", 32'(IM_Req), 32'h0);
         chk("hold_instr", ID_Instruction, 32'h2008_0041);
         chk("hold_pc", IF_PC, 32'h8000_0044);
      end
      ID_Stall = 1'b0;
      tick();
      chk("rel_instr", ID_Instruction, 32'h2008_0045);
      chk("rel_pc4", ID_PCPlus4, 32'h8000_0048);
      chk("rel_addr", IM_Addr, 32'h8000_0048);
      chk("rel_req", 32'(IM_Req), 32'h1);

      // jump while request outstanding -> drain
      IM_Ready      = 1'b0;
      ID_Jump       = 1'b1;
      ID_JumpTarget = 32'h8000_0100;
      tick();
      ID_Jump = 1'b0;
      chk("drn_addr", IM_Addr, 32'h8000_0048);
      chk("drn_req", 32'(IM_Req), 32'h1);
      chk("drn_pc", IF_PC, 32'h8000_0100);
      chk("drn_valid", 32'(ID_Valid), 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("drn_hold_addr", IM_Addr, 32'h8000_0048);
      end
      IM_Ready = 1'b1;
      tick();
      chk("drn_done_addr", IM_Addr, 32'h8000_0100);
      chk("drn_done_valid", 32'(ID_Valid), 32'(DS));
      tick();
      chk("jmp_tgt_instr", ID_Instruction, 32'h2008_0101);

      // interrupt from user-mode PC
      ID_Jump       = 1'b1;
      ID_JumpTarget = 32'h0000_0020;
      tick();
      ID_Jump = 1'b0;
      chk("usr_addr", IM_Addr, 32'h0000_0020);
      chk("usr_valid", 32'(ID_Valid), 32'(DS));
      tick();
      chk("usr_instr", ID_Instruction, 32'h2008_0021);
      IRQ = 1'b1;
      tick();
      chk("irq_addr", IM_Addr, 32'h8000_0004);
      chk("irq_valid", 32'(ID_Valid), 32'h0);
      chk("irq_instr", ID_Instruction, 32'h0);
      tick();
      chk("irq_masked_addr", IM_Addr, 32'h8000_0008);
      chk("irq_masked_valid", 32'(ID_Valid), 32'h1);
      IRQ = 1'b0;
      tick();
      chk("pre_exc_addr", IM_Addr, 32'h8000_000C);

      // exception beats stalled taken branch
      Exception       = 1'b1;
      ID_IsBranch     = 1'b1;
      ID_Taken        = 1'b1;
      ID_BranchTarget = 32'h8000_0040;
      ID_Stall        = 1'b1;
      #1;
      chk("epc_pc4", ID_PCPlus4, 32'h8000_000C);
      tick();
      Exception   = 1'b0;
      ID_IsBranch = 1'b0;
      ID_Taken    = 1'b0;
      ID_Stall    = 1'b0;
      chk("exc_addr", IM_Addr, 32'h8000_0008);
      chk("exc_valid", 32'(ID_Valid), 32'h0);
      tick();

      // jump beats branch; bit 31 preserved across wrap
      ID_Jump         = 1'b1;
      ID_JumpTarget   = 32'h7FFF_FFFC;
      ID_IsBranch     = 1'b1;
      ID_Taken        = 1'b1;
      ID_BranchTarget = 32'h8000_0040;
      tick();
      ID_Jump     = 1'b0;
      ID_IsBranch = 1'b0;
      ID_Taken    = 1'b0;
      chk("jb_addr", IM_Addr, 32'h7FFF_FFFC);
      tick();
      chk("wrap_addr", IM_Addr, 32'h0000_0000);
      chk("wrap_pc4", ID_PCPlus4, 32'h0000_0000);
      chk("wrap_instr", ID_Instruction, 32'h2008_FFFD);

      // reset asserted during drain
      IM_Ready  = 1'b0;
      Exception = 1'b1;
      tick();
      Exception = 1'b0;
      chk("rd_addr", IM_Addr, 32'h0000_0000);
      chk("rd_pc", IF_PC, 32'h8000_0008);
      #2;
      reset = 1'b1;
      #1;
      chk("async_req", 32'(IM_Req), 32'h0);
      chk("async_pc", IF_PC, 32'h8000_0000);
      chk("async_addr", IM_Addr, 32'h8000_0000);
      chk("async_valid", 32'(ID_Valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
